// File: rtl/weights_pkg.sv
// rtl/weights_pkg.sv - shared widths and state encoding for the weights loader
// Contents:
//   WEIGHT_ADDR_W  : width of the weights memory port-A address (13)
//   WEIGHT_DATA_W  : width of one weight word (16)
//   loader_state_t : loader FSM states
package weights_pkg;

  localparam int WEIGHT_ADDR_W = 13;
  localparam int WEIGHT_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - up counter with synchronous clear and programmable rollover
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   clear          : forces count to 0 on the next edge
//   count_enable   : advances count by one (wrapping to 0 after rollover_val)
//   rollover_val   : last value before the count wraps
//   count          : current count
//   at_rollover    : count equals rollover_val
module flex_counter #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count,
  output logic             at_rollover
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count_enable) begin
      if (count == rollover_val) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign at_rollover = (count == rollover_val);

endmodule

// File: rtl/weights_loader.sv
// rtl/weights_loader.sv - assembles byte stream into 16-bit words and writes them to weights memory port A
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   start         : one-cycle pulse that begins a load (honoured only when idle)
//   abort         : cancels the load in progress
//   byte_in       : weight data byte, low byte first
//   byte_valid    : byte_in is valid
//   byte_ready    : loader accepts byte_in this cycle
//   mem_address   : port-A write address (word counter)
//   mem_data      : port-A write data
//   mem_wren      : port-A write enable
//   mem_select    : routes the loader's address onto memory port A
//   busy          : load in progress
//   done          : one-cycle pulse when a full load completes
module weights_loader
  import weights_pkg::*;
#(
  parameter int NUM_WEIGHTS = 8192
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic [WEIGHT_ADDR_W-1:0] mem_address,
  output logic [WEIGHT_DATA_W-1:0] mem_data,
  output logic                     mem_wren,
  output logic                     mem_select,
  output logic                     busy,
  output logic                     done
);

  localparam logic [WEIGHT_ADDR_W-1:0] LAST_ADDR = WEIGHT_ADDR_W'(NUM_WEIGHTS - 1);

  loader_state_t              state;
  loader_state_t              state_next;
  logic [WEIGHT_DATA_W-1:0]   data_reg;
  logic                       cnt_clear;
  logic                       cnt_en;
  logic                       load_low;
  logic                       load_high;
  logic                       last_word;

  // The counter stops at LAST_ADDR: the FSM moves to DONE instead of
  // enabling it there, so the rollover never actually occurs mid-load.
  flex_counter #(
    .WIDTH (WEIGHT_ADDR_W)
  ) u_word_counter (
    .clk          (clk),
    .rst          (rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (LAST_ADDR),
    .count        (mem_address),
    .at_rollover  (last_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      data_reg <= '0;
    end else begin
      state <= state_next;
      if (load_low) begin
        data_reg[7:0] <= byte_in;
      end
      if (load_high) begin
        data_reg[15:8] <= byte_in;
      end
    end
  end

  // Abort is tested before byte_valid so a byte presented alongside abort
  // is dropped. In WRITE the enable is already decoded from state, so an
  // abort there only suppresses the follow-on LOW/DONE step.
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    load_low   = 1'b0;
    load_high  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOW;
          cnt_clear  = 1'b1;
        end
      end
      ST_LOW: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (byte_valid) begin
          load_low   = 1'b1;
          state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (byte_valid) begin
          load_high  = 1'b1;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (last_word) begin
          state_next = ST_DONE;
        end else begin
          cnt_en     = 1'b1;
          state_next = ST_LOW;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // All control outputs are pure state decodes, keeping byte_valid off
  // any combinational path to the memory port.
  assign byte_ready = (state == ST_LOW) || (state == ST_HIGH);
  assign mem_wren   = (state == ST_WRITE);
  assign busy       = (state == ST_LOW) || (state == ST_HIGH) || (state == ST_WRITE);
  assign mem_select = busy;
  assign done       = (state == ST_DONE);
  assign mem_data   = data_reg;

endmodule

// File: doc/weights_loader.md
WEIGHTS_LOADER -- requirements
Module: weights_loader

Interface
REQ-001 The block SHALL have parameter NUM_WEIGHTS, default 8192, meaning the number of 16-bit words written per load; legal range is 1..8192.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a load.
REQ-005 The block SHALL have port abort, input, 1 bit: cancels the load in progress.
REQ-006 The block SHALL have port byte_in, input, 8 bits: weight data byte.
REQ-007 The block SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-008 The block SHALL have port byte_ready, output, 1 bit: the loader accepts byte_in this cycle.
REQ-009 The block SHALL have port mem_address, output, 13 bits: port-A write address, connected to address_a_2 of the weights memory.
REQ-010 The block SHALL have port mem_data, output, 16 bits: port-A write data.
REQ-011 The block SHALL have port mem_wren, output, 1 bit: port-A write enable.
REQ-012 The block SHALL have port mem_select, output, 1 bit: selects the loader's address onto memory port A.
REQ-013 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a load completes.

Function
REQ-015 The FSM SHALL have states IDLE, LOW, HIGH, WRITE and DONE.
REQ-016 IDLE with start=1 SHALL go to LOW and clear the word counter to 0; start in any other state SHALL be ignored.
REQ-017 byte_ready SHALL be 1 only in LOW and HIGH; a byte SHALL be accepted in a cycle only when byte_valid=1 and byte_ready=1.
REQ-018 In LOW, an accepted byte SHALL be stored as mem_data[7:0] and the FSM SHALL go to HIGH.
REQ-019 In HIGH, an accepted byte SHALL be stored as mem_data[15:8] and the FSM SHALL go to WRITE; bytes are little-endian.
REQ-020 In LOW or HIGH with byte_valid=0, the FSM SHALL hold state.
REQ-021 In WRITE, mem_wren SHALL be 1 for exactly one cycle with mem_address equal to the word counter; write latency is 1 cycle after high-byte acceptance.
REQ-022 After WRITE, if counter = NUM_WEIGHTS-1 the FSM SHALL go to DONE; otherwise the counter SHALL increment and the FSM SHALL go to LOW.
REQ-023 DONE SHALL assert done for one cycle, then go to IDLE; the counter SHALL not wrap past NUM_WEIGHTS-1.
REQ-024 busy and mem_select SHALL be 1 in LOW, HIGH and WRITE, and 0 in IDLE and DONE.
REQ-025 mem_wren SHALL be 0 in every state except WRITE.
REQ-026 abort=1 in LOW or HIGH SHALL go to IDLE the next cycle; the byte presented that cycle SHALL be discarded and no write issued.
REQ-027 abort=1 in WRITE SHALL let the write complete, then go to IDLE with no done pulse.
REQ-028 abort SHALL take priority over byte acceptance; abort in IDLE or DONE SHALL have no effect.
REQ-029 When abort and start are both 1 in IDLE, start SHALL win.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL enter IDLE and clear the counter and data register to 0.
REQ-031 After reset, outputs SHALL be: byte_ready=0, mem_wren=0, mem_select=0, busy=0, done=0, mem_address=0, mem_data=0.
REQ-032 Reset asserted mid-load SHALL abandon the load with no write and no done pulse.

Structure
REQ-033 Package weights_pkg SHALL hold WEIGHT_ADDR_W=13, WEIGHT_DATA_W=16 and the loader state enum.
REQ-034 The word counter SHALL be a flex_counter sub-module instance, 13 bits wide, with clear and count_enable, rolling over at NUM_WEIGHTS-1.
REQ-035 Outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from byte_valid to mem_wren.

Verification
REQ-036 NUM_WEIGHTS=2, start, then bytes 0x34,0x12,0x78,0x56 -> writes 0x1234 @0 and 0x5678 @1, then one done pulse, then busy=0.
REQ-037 byte_valid toggled 1-0-1-0 during a load -> no lost or duplicated bytes; data is identical to the gap-free case.
REQ-038 Abort after 3 bytes with NUM_WEIGHTS=4 -> one write (@0), back in IDLE, no done; a fresh start rewrites from address 0.
REQ-039 rst asserted while in HIGH -> all outputs equal their reset values the next cycle; no mem_wren pulse.
REQ-040 start pulsed again while busy -> ignored; the counter and address sequence are unaffected.
REQ-041 NUM_WEIGHTS=8192, full load of incrementing data -> last write at address 0x1FFF, exactly 8192 mem_wren pulses.
